// File: rtl/eth_measurer_pkg.sv
// Shared definitions for the eth_measurer transmit and receive sides:
// frame field offsets, header length, parser state encoding and the
// helper that picks the expected header byte for a given frame offset.
package eth_measurer_pkg;

   // Byte offsets of the fixed header fields inside a measurement frame
   localparam logic [4:0] DST_MAC_OFFSET   = 5'd0;
   localparam logic [4:0] SRC_MAC_OFFSET   = 5'd6;
   localparam logic [4:0] ETHERTYPE_OFFSET = 5'd12;
   localparam logic [4:0] IDENT_OFFSET     = 5'd14;
   localparam logic [4:0] ID_OFFSET        = 5'd18;

   // Header spans bytes 0..21; the sequence number occupies the last four
   localparam int         HEADER_LEN  = 22;
   localparam logic [4:0] HEADER_LAST = 5'(HEADER_LEN - 1);

   // Parser states
   localparam logic [1:0] ST_HEADER = 2'd0;
   localparam logic [1:0] ST_SKIP   = 2'd1;
   localparam logic [1:0] ST_DROP   = 2'd2;

   // Returns the byte a matching frame must carry at header offset idx.
   // Offsets at or beyond the sequence number field have no fixed value.
   function automatic logic [7:0] expected_byte(
      input logic [4:0]  idx,
      input logic [47:0] dst,
      input logic [47:0] src,
      input logic [15:0] etype,
      input logic [31:0] ident
   );
      logic [4:0]  rel;
      logic [47:0] mac;
      logic [15:0] et;
      logic [31:0] idf;
      expected_byte = 8'h00;
      rel = 5'd0;
      mac = 48'h0;
      et  = 16'h0;
      idf = 32'h0;
      if (idx < SRC_MAC_OFFSET) begin
         rel = idx - DST_MAC_OFFSET;
         mac = dst << {rel, 3'b000};
         expected_byte = mac[47:40];
      end else if (idx < ETHERTYPE_OFFSET) begin
         rel = idx - SRC_MAC_OFFSET;
         mac = src << {rel, 3'b000};
         expected_byte = mac[47:40];
      end else if (idx < IDENT_OFFSET) begin
         rel = idx - ETHERTYPE_OFFSET;
         et = etype << {rel, 3'b000};
         expected_byte = et[15:8];
      end else if (idx < ID_OFFSET) begin
         rel = idx - IDENT_OFFSET;
         idf = ident << {rel, 3'b000};
         expected_byte = idf[31:24];
      end
   endfunction

endpackage

// File: rtl/eth_rx_sat_counter.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module eth_rx_sat_counter
   import eth_measurer_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        inc,
   output logic [31:0] count
);

   // Count one event per cycle while inc is high, holding at the maximum
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= 32'h0;
      end else if (inc && (count != 32'hFFFF_FFFF)) begin
         count <= count + 32'd1;
      end
   end

endmodule

// File: rtl/eth_measurer_rx.sv
// Receive side of the Ethernet latency measurer. Parses the TEMAC byte
// stream, checks the fixed measurement header, extracts the sequence
// number and reports accepted frames together with their arrival time.
module eth_measurer_rx
   import eth_measurer_pkg::*;
#(
   parameter logic [47:0] src_mac    = 48'hDE_AD_BE_EF_01_01,
   parameter logic [47:0] dst_mac    = 48'hDE_AD_BE_EF_01_02,
   parameter logic [31:0] identifier = 32'hCAFECAFE,
   parameter logic [15:0] ethertype  = 16'h88B5
)(
   input  logic        s_axis_clk,
   input  logic        s_axis_resetn,
   input  logic [7:0]  s_axis_tdata,
   input  logic        s_axis_tkeep,
   input  logic        s_axis_tlast,
   input  logic        s_axis_tvalid,
   input  logic        s_axis_tuser,
   input  logic        enable,
   input  logic [63:0] current_time,
   output logic        ping_valid,
   output logic [31:0] ping_id,
   output logic [63:0] ping_time,
   output logic [31:0] rx_ok,
   output logic [31:0] rx_dropped
);

   logic [1:0]  state, state_next;
   logic [4:0]  byte_cnt, byte_cnt_next;
   logic        drop_counted, drop_counted_next;
   logic [31:0] id_stage, id_stage_next;
   logic [63:0] time_stage;
   logic        accept, drop;
   logic        is_byte, is_end, byte_match, first_byte;

   assign is_byte    = s_axis_tvalid && s_axis_tkeep;
   assign is_end     = s_axis_tvalid && s_axis_tlast;
   assign first_byte = is_byte && (state == ST_HEADER) && (byte_cnt == 5'd0);
   assign byte_match = (byte_cnt >= ID_OFFSET) ||
                       (s_axis_tdata == expected_byte(byte_cnt, dst_mac, src_mac,
                                                      ethertype, identifier));

   // Parser next state, sequence-number capture and end-of-frame verdict.
   // drop_counted remembers whether a DROP frame must be reported, since a
   // frame discarded because enable was low is not counted anywhere.
   always_comb begin
      state_next        = state;
      byte_cnt_next     = byte_cnt;
      drop_counted_next = drop_counted;
      id_stage_next     = id_stage;
      accept            = 1'b0;
      drop              = 1'b0;
      case (state)
         ST_HEADER: begin
            if (is_byte) begin
               if ((byte_cnt == 5'd0) && !enable) begin
                  state_next        = ST_DROP;
                  drop_counted_next = 1'b0;
               end else if (!byte_match) begin
                  state_next        = ST_DROP;
                  drop_counted_next = 1'b1;
               end else begin
                  if (byte_cnt >= ID_OFFSET) begin
                     id_stage_next = {id_stage[23:0], s_axis_tdata};
                  end
                  if (byte_cnt == HEADER_LAST) begin
                     state_next = ST_SKIP;
                  end else begin
                     byte_cnt_next = byte_cnt + 5'd1;
                  end
               end
            end
            if (is_end) begin
               if (state_next == ST_SKIP) begin
                  accept = !s_axis_tuser;
                  drop   = s_axis_tuser;
               end else if (state_next == ST_DROP) begin
                  drop = drop_counted_next;
               end else begin
                  drop = 1'b1;
               end
            end
         end
         ST_SKIP: begin
            if (is_end) begin
               accept = !s_axis_tuser;
               drop   = s_axis_tuser;
            end
         end
         ST_DROP: begin
            if (is_end) begin
               drop = drop_counted;
            end
         end
         default: begin
            state_next = ST_HEADER;
         end
      endcase
      if (is_end) begin
         state_next    = ST_HEADER;
         byte_cnt_next = 5'd0;
      end
   end

   // Parser state registers
   always_ff @(posedge s_axis_clk or negedge s_axis_resetn) begin
      if (!s_axis_resetn) begin
         state        <= ST_HEADER;
         byte_cnt     <= 5'd0;
         drop_counted <= 1'b0;
         id_stage     <= 32'h0;
      end else begin
         state        <= state_next;
         byte_cnt     <= byte_cnt_next;
         drop_counted <= drop_counted_next;
         id_stage     <= id_stage_next;
      end
   end

   // Arrival timestamp is taken on the first byte of every frame
   always_ff @(posedge s_axis_clk or negedge s_axis_resetn) begin
      if (!s_axis_resetn) begin
         time_stage <= 64'h0;
      end else if (first_byte) begin
         time_stage <= current_time;
      end
   end

   // Publish the accepted frame one cycle after its last beat
   always_ff @(posedge s_axis_clk or negedge s_axis_resetn) begin
      if (!s_axis_resetn) begin
         ping_valid <= 1'b0;
         ping_id    <= 32'h0;
         ping_time  <= 64'h0;
      end else begin
         ping_valid <= accept;
         if (accept) begin
            ping_id   <= id_stage_next;
            ping_time <= time_stage;
         end
      end
   end

   eth_rx_sat_counter u_ok_cnt (
      .clk   (s_axis_clk),
      .rst_n (s_axis_resetn),
      .inc   (accept),
      .count (rx_ok)
   );

   eth_rx_sat_counter u_drop_cnt (
      .clk   (s_axis_clk),
      .rst_n (s_axis_resetn),
      .inc   (drop),
      .count (rx_dropped)
   );

endmodule

// File: tb/tb_eth_measurer_rx.sv
// Directed self-checking bench for eth_measurer_rx.
module tb_eth_measurer_rx;

   localparam logic [47:0] TB_DST   = 48'hDEADBEEF0102;
   localparam logic [47:0] TB_SRC   = 48'hDEADBEEF0101;
   localparam logic [15:0] TB_ETYPE = 16'h88B5;
   localparam logic [31:0] TB_IDENT = 32'hCAFECAFE;

   logic        clk;
   logic        rst_n;
   logic [7:0]  tdata;
   logic        tkeep;
   logic        tlast;
   logic        tvalid;
   logic        tuser;
   logic        enable;
   logic [63:0] current_time;
   logic        ping_valid;
   logic [31:0] ping_id;
   logic [63:0] ping_time;
   logic [31:0] rx_ok;
   logic [31:0] rx_dropped;

   int          numCompared;
   int          numMismatched;
   int          pulseCount;
   logic [31:0] pulseIds [0:3];

   eth_measurer_rx dut (
      .s_axis_clk    (clk),
      .s_axis_resetn (rst_n),
      .s_axis_tdata  (tdata),
      .s_axis_tkeep  (tkeep),
      .s_axis_tlast  (tlast),
      .s_axis_tvalid (tvalid),
      .s_axis_tuser  (tuser),
      .enable        (enable),
      .current_time  (current_time),
      .ping_valid    (ping_valid),
      .ping_id       (ping_id),
      .ping_time     (ping_time),
      .rx_ok         (rx_ok),
      .rx_dropped    (rx_dropped)
   );

   // 100 MHz clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Record every ping pulse so back-to-back frames can be checked afterwards
   always @(negedge clk) begin
      if (ping_valid) begin
         if (pulseCount < 4) pulseIds[pulseCount] = ping_id;
         pulseCount = pulseCount + 1;
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      numCompared = numCompared + 1;
      if (observed !== expected) begin
         numMismatched = numMismatched + 1;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [7:0] d, input logic k,
                                input logic l, input logic u, input logic [63:0] t);
      @(negedge clk);
      tvalid       = v;
      tdata        = d;
      tkeep        = k;
      tlast        = l;
      tuser        = u;
      current_time = t;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 64'h0);
   endtask

   function automatic logic [7:0] frameByte(input logic [31:0] id, input int i);
      logic [143:0] hdr;
      logic [31:0]  idv;
      hdr = {TB_DST, TB_SRC, TB_ETYPE, TB_IDENT};
      idv = id;
      if (i < 18) begin
         hdr = hdr << (8 * i);
         return hdr[143:136];
      end else if (i < 22) begin
         idv = idv << (8 * (i - 18));
         return idv[31:24];
      end
      return 8'(i);
   endfunction

   // Sends bytes first..len-1 of a frame; optional corrupted byte, bad-frame
   // flag on the last beat, and keep/valid bubbles before two chosen bytes.
   task automatic sendFrame(input logic [31:0] id, input int first, input int len,
                            input int badIdx, input logic user, input int bubbleA,
                            input int bubbleB, input logic [63:0] t0);
      logic [7:0] b;
      for (int i = first; i < len; i++) begin
         if (i == bubbleA || i == bubbleB) begin
            applyStimulus(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, t0 + 64'(i));
            applyStimulus(1'b0, 8'hAA, 1'b1, 1'b0, 1'b0, t0 + 64'(i));
         end
         b = frameByte(id, i);
         if (i == badIdx) b = b ^ 8'hFF;
         applyStimulus(1'b1, b, 1'b1, (i == len - 1), (i == len - 1) ? user : 1'b0,
                       t0 + 64'(i));
      end
   endtask

   task automatic doReset();
      @(negedge clk);
      rst_n = 1'b0;
      tvalid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      numCompared   = 0;
      numMismatched = 0;
      pulseCount    = 0;
      for (int i = 0; i < 4; i++) pulseIds[i] = 32'h0;
      rst_n        = 1'b0;
      tvalid       = 1'b0;
      tdata        = 8'h00;
      tkeep        = 1'b0;
      tlast        = 1'b0;
      tuser        = 1'b0;
      enable       = 1'b1;
      current_time = 64'h0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Reset state
      checkOutput("rst_ping_valid", 64'(ping_valid), 64'h0);
      checkOutput("rst_ping_id", 64'(ping_id), 64'h0);
      checkOutput("rst_ping_time", ping_time, 64'h0);
      checkOutput("rst_rx_ok", 64'(rx_ok), 64'h0);
      checkOutput("rst_rx_dropped", 64'(rx_dropped), 64'h0);

      // Valid 60-byte frame
      sendFrame(32'h5, 0, 60, -1, 1'b0, -1, -1, 64'd1000);
      idle(1);
      checkOutput("ok_ping_valid", 64'(ping_valid), 64'h1);
      checkOutput("ok_ping_id", 64'(ping_id), 64'h5);
      checkOutput("ok_ping_time", ping_time, 64'd1000);
      checkOutput("ok_rx_ok", 64'(rx_ok), 64'h1);
      checkOutput("ok_rx_dropped", 64'(rx_dropped), 64'h0);
      idle(1);
      checkOutput("ok_pulse_width", 64'(ping_valid), 64'h0);

      // Same frame with destination byte 3 corrupted
      sendFrame(32'h9, 0, 60, 3, 1'b0, -1, -1, 64'd3000);
      idle(1);
      checkOutput("bad_ping_valid", 64'(ping_valid), 64'h0);
      checkOutput("bad_rx_dropped", 64'(rx_dropped), 64'h1);
      checkOutput("bad_ping_id", 64'(ping_id), 64'h5);
      checkOutput("bad_ping_time", ping_time, 64'd1000);
      checkOutput("bad_rx_ok", 64'(rx_ok), 64'h1);

      // Runt then exact-length header-only frame
      doReset();
      sendFrame(32'h7, 0, 18, -1, 1'b0, -1, -1, 64'd1500);
      idle(1);
      checkOutput("runt_ping_valid", 64'(ping_valid), 64'h0);
      checkOutput("runt_rx_dropped", 64'(rx_dropped), 64'h1);
      sendFrame(32'h11223344, 0, 22, -1, 1'b0, -1, -1, 64'd2000);
      idle(1);
      checkOutput("exact_ping_valid", 64'(ping_valid), 64'h1);
      checkOutput("exact_ping_id", 64'(ping_id), 64'h11223344);
      checkOutput("exact_ping_time", ping_time, 64'd2000);
      checkOutput("exact_rx_ok", 64'(rx_ok), 64'h1);

      // Bad-frame flag, then a frame arriving while disabled
      doReset();
      sendFrame(32'h21, 0, 30, -1, 1'b1, -1, -1, 64'd4000);
      idle(1);
      checkOutput("tuser_ping_valid", 64'(ping_valid), 64'h0);
      checkOutput("tuser_rx_dropped", 64'(rx_dropped), 64'h1);
      checkOutput("tuser_rx_ok", 64'(rx_ok), 64'h0);
      enable = 1'b0;
      sendFrame(32'h22, 0, 30, -1, 1'b0, -1, -1, 64'd5000);
      idle(1);
      enable = 1'b1;
      checkOutput("dis_ping_valid", 64'(ping_valid), 64'h0);
      checkOutput("dis_rx_dropped", 64'(rx_dropped), 64'h1);
      checkOutput("dis_rx_ok", 64'(rx_ok), 64'h0);

      // Back-to-back frames with bubbles inside the header
      doReset();
      pulseCount = 0;
      sendFrame(32'hA1, 0, 25, -1, 1'b0, 5, 19, 64'd6000);
      sendFrame(32'hA2, 0, 25, -1, 1'b0, 2, 20, 64'd7000);
      idle(3);
      checkOutput("b2b_pulses", 64'(pulseCount), 64'd2);
      checkOutput("b2b_id0", 64'(pulseIds[0]), 64'hA1);
      checkOutput("b2b_id1", 64'(pulseIds[1]), 64'hA2);
      checkOutput("b2b_rx_ok", 64'(rx_ok), 64'h2);
      checkOutput("b2b_ping_time", ping_time, 64'd7000);

      // Reset in the middle of a frame, remainder must be dropped
      sendFrame(32'hB0, 0, 10, -1, 1'b0, -1, -1, 64'd8000);
      @(negedge clk);
      rst_n  = 1'b0;
      tvalid = 1'b0;
      #1;
      checkOutput("mid_ping_valid", 64'(ping_valid), 64'h0);
      checkOutput("mid_ping_id", 64'(ping_id), 64'h0);
      checkOutput("mid_ping_time", ping_time, 64'h0);
      checkOutput("mid_rx_ok", 64'(rx_ok), 64'h0);
      checkOutput("mid_rx_dropped", 64'(rx_dropped), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      sendFrame(32'hB0, 10, 60, -1, 1'b0, -1, -1, 64'd8100);
      idle(1);
      checkOutput("rem_ping_valid", 64'(ping_valid), 64'h0);
      checkOutput("rem_rx_dropped", 64'(rx_dropped), 64'h1);
      checkOutput("rem_rx_ok", 64'(rx_ok), 64'h0);

      // Saturation of the accepted-frame counter
      force dut.u_ok_cnt.count = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.u_ok_cnt.count;
      @(negedge clk);
      checkOutput("sat_preload", 64'(rx_ok), 64'hFFFF_FFFF);
      sendFrame(32'hC3, 0, 40, -1, 1'b0, -1, -1, 64'd9000);
      idle(1);
      checkOutput("sat_ping_valid", 64'(ping_valid), 64'h1);
      checkOutput("sat_ping_id", 64'(ping_id), 64'hC3);
      checkOutput("sat_rx_ok", 64'(rx_ok), 64'hFFFF_FFFF);
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
      $finish;
   end

endmodule
